// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO types and default sizes
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam int DSIZE = 6;
    localparam int ASIZE = 4;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin picker (pick=1 selects requester 1)
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    output logic       pick,
    output logic       any
);

    assign any  = |valid;
    // On contention the requester that was not served last wins.
    assign pick = (&valid) ? ~rr_last : valid[1];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the FIFO write port
module fifo_wr_arbiter #(
    parameter int DSIZE     = fifo_pkg::DSIZE,
    parameter int MAX_BURST = 4
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             req0_valid,
    input  logic [DSIZE-1:0] req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [DSIZE-1:0] req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    input  logic             wfull,
    output logic             wclk_en,
    output logic [DSIZE-1:0] wdata,
    output logic [1:0]       grant
);

    import fifo_pkg::*;

    localparam int            CW       = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    arb_state_t    state;
    logic [CW-1:0] burst_cnt;
    logic          rr_last;
    logic          pick;
    logic          any;
    logic          own0;
    logic          own1;
    logic          xfer_last;
    logic          other_valid;
    logic          rel;

    rr_pick2 u_pick (
        .valid   ({req1_valid, req0_valid}),
        .rr_last (rr_last),
        .pick    (pick),
        .any     (any)
    );

    assign own0  = (state == ST_OWN0);
    assign own1  = (state == ST_OWN1);
    assign grant = {own1, own0};

    // Ready is gated by wrst so that nothing is written in a reset cycle.
    always_comb begin
        req0_ready  = own0 & ~wfull & ~wrst;
        req1_ready  = own1 & ~wfull & ~wrst;
        wclk_en     = (req0_ready & req0_valid) | (req1_ready & req1_valid);
        wdata       = own0 ? req0_data : (own1 ? req1_data : '0);
        xfer_last   = own1 ? req1_last : req0_last;
        other_valid = own1 ? req0_valid : req1_valid;
        rel         = wclk_en & (xfer_last | (burst_cnt == LAST_CNT));
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            rr_last   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    burst_cnt <= '0;
                    if (any) begin
                        state <= pick ? ST_OWN1 : ST_OWN0;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (wclk_en) begin
                        if (rel) begin
                            rr_last   <= own1;
                            burst_cnt <= '0;
                            // A forced release without last keeps the owner busy if nobody else waits.
                            if (other_valid) begin
                                state <= own1 ? ST_OWN0 : ST_OWN1;
                            end else if (xfer_last) begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
